// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer
//
// Autonomous Avalon master for the flash interface control block. A single
// start request becomes the whole command sequence for a 4 KB sector erase
// or a page program: write enable, address load, data FIFO fill, command
// issue, then status-register polling until the flash reports not busy.
//
// Ports
//   i_Clk, i_nReset          clock (rising edge), async active-low reset
//   i_Start, i_Op            one-cycle request, 0 = erase 4 KB, 1 = program
//   i_FlashAddr, i_WordCount byte address and program word count (1..64)
//   i_WrData, i_WrValid,     program data stream, word taken when
//   o_WrReady                i_WrValid && o_WrReady
//   o_Busy, o_Done, o_Error  status; Done/Error are one-cycle pulses
//   o_AV_*, i_AV_*           Avalon-MM master towards the control slave
module flash_op_sequencer #(
  parameter logic [29:0] BASE_ADDR  = 30'h20000000,
  parameter int          POLL_LIMIT = 65535
) (
  input  logic        i_Clk,
  input  logic        i_nReset,
  input  logic        i_Start,
  input  logic        i_Op,
  input  logic [23:0] i_FlashAddr,
  input  logic [6:0]  i_WordCount,
  input  logic [31:0] i_WrData,
  input  logic        i_WrValid,
  output logic        o_WrReady,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Error,
  output logic [29:0] o_AV_Addr,
  output logic [3:0]  o_AV_ByteEn,
  output logic        o_AV_Read,
  output logic        o_AV_Write,
  output logic [31:0] o_AV_WriteData,
  input  logic [31:0] i_AV_ReadData,
  input  logic        i_AV_WaitRequest
);

  localparam logic [29:0] CNTRL_ADDR = BASE_ADDR;
  localparam logic [29:0] ADDR_ADDR  = BASE_ADDR + 30'd1;
  localparam logic [29:0] DATA_ADDR  = BASE_ADDR + 30'd2;

  localparam logic [3:0] CMD_WRITE_ENABLE = 4'd0;
  localparam logic [3:0] CMD_SECTOR_ERASE = 4'd2;
  localparam logic [3:0] CMD_PROGRAM_PAGE = 4'd5;
  localparam logic [3:0] CMD_READ_SR      = 4'd7;

  // Last poll index that may still be busy before giving up.
  localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WEN,
    S_WEN_WAIT,
    S_ADDR,
    S_FILL,
    S_CMD,
    S_CMD_WAIT,
    S_SR_SEL,
    S_SR_CMD,
    S_SR_WAIT,
    S_SR_READ,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;
  state_t state_next;

  logic        op_r;
  logic [23:0] addr_r;
  logic [6:0]  count_r;
  logic [6:0]  words_sent;
  logic [15:0] poll_cnt;

  logic xfer_active;
  logic xfer_done;
  logic ctl_busy;
  logic sr_busy;
  logic count_ok;
  logic start_ok;
  logic wr_fire;

  logic        av_read_d;
  logic        av_write_d;
  logic [29:0] av_addr_d;
  logic [31:0] av_wdata_d;
  logic [3:0]  av_be_d;

  // Only bit 31 of CNTRL and bit 0 of SR1 carry meaning for this master.
  logic unused_readdata;
  assign unused_readdata = &{1'b0, i_AV_ReadData[30:1]};

  // Control word: [3:0] command, [8] go, [22:16] word count.
  function automatic logic [31:0] ctrl_word(input logic [3:0] cmd,
                                            input logic [6:0] count);
    ctrl_word = {9'd0, count, 7'd0, 1'b1, 4'd0, cmd};
  endfunction

  // A transfer finishes on the edge where the slave drops wait request.
  assign xfer_active = o_AV_Read | o_AV_Write;
  assign xfer_done   = xfer_active & ~i_AV_WaitRequest;
  assign ctl_busy    = i_AV_ReadData[31];
  assign sr_busy     = i_AV_ReadData[0];

  // Program counts outside 1..64 are refused; erase ignores the count.
  assign count_ok = (i_WordCount != 7'd0) && (i_WordCount <= 7'd64);
  assign start_ok = i_Start & (~i_Op | count_ok);

  // Ready is withheld while a DATA write is still in flight so the word
  // register is never overwritten before the slave takes it.
  assign wr_fire = (state == S_FILL) & ~xfer_active & i_WrValid;

  // State register.
  always_ff @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Every transfer state advances only when its own
  // transfer completes; CNTRL wait states loop while the interface is busy.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_Start) begin
          state_next = start_ok ? S_WEN : S_ERR;
        end
      end
      S_WEN: begin
        if (xfer_done) state_next = S_WEN_WAIT;
      end
      S_WEN_WAIT: begin
        if (xfer_done && !ctl_busy) state_next = S_ADDR;
      end
      S_ADDR: begin
        if (xfer_done) state_next = op_r ? S_FILL : S_CMD;
      end
      S_FILL: begin
        if (xfer_done && (words_sent == count_r)) state_next = S_CMD;
      end
      S_CMD: begin
        if (xfer_done) state_next = S_CMD_WAIT;
      end
      S_CMD_WAIT: begin
        if (xfer_done && !ctl_busy) state_next = S_SR_SEL;
      end
      S_SR_SEL: begin
        if (xfer_done) state_next = S_SR_CMD;
      end
      S_SR_CMD: begin
        if (xfer_done) state_next = S_SR_WAIT;
      end
      S_SR_WAIT: begin
        if (xfer_done && !ctl_busy) state_next = S_SR_READ;
      end
      S_SR_READ: begin
        if (xfer_done) begin
          if (!sr_busy) begin
            state_next = S_DONE;
          end else if (poll_cnt == POLL_LAST) begin
            state_next = S_ERR;
          end else begin
            state_next = S_SR_SEL;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic. Status flags decode the state directly. The Avalon
  // request is computed here and registered below: a completing transfer
  // drops its strobes, and a new one is launched only from a state with
  // nothing in flight, which guarantees an idle cycle between transfers.
  // The write-enable write launches straight from IDLE so it appears in
  // the cycle after the start edge.
  always_comb begin
    o_Busy     = 1'b1;
    o_Done     = 1'b0;
    o_Error    = 1'b0;
    o_WrReady  = 1'b0;
    av_read_d  = o_AV_Read;
    av_write_d = o_AV_Write;
    av_addr_d  = o_AV_Addr;
    av_wdata_d = o_AV_WriteData;
    av_be_d    = o_AV_ByteEn;

    case (state)
      S_IDLE:  o_Busy = 1'b0;
      S_DONE: begin
        o_Busy = 1'b0;
        o_Done = 1'b1;
      end
      S_ERR: begin
        o_Busy  = 1'b0;
        o_Error = 1'b1;
      end
      S_FILL:  o_WrReady = ~xfer_active;
      default: ;
    endcase

    if (xfer_done) begin
      av_read_d  = 1'b0;
      av_write_d = 1'b0;
      av_be_d    = 4'b0000;
    end else if (!xfer_active) begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            av_write_d = 1'b1;
            av_addr_d  = CNTRL_ADDR;
            av_wdata_d = ctrl_word(CMD_WRITE_ENABLE, 7'd0);
            av_be_d    = 4'b1111;
          end
        end
        S_WEN_WAIT, S_CMD_WAIT, S_SR_WAIT: begin
          av_read_d = 1'b1;
          av_addr_d = CNTRL_ADDR;
          av_be_d   = 4'b1111;
        end
        S_ADDR: begin
          av_write_d = 1'b1;
          av_addr_d  = ADDR_ADDR;
          av_wdata_d = {8'h00, addr_r};
          av_be_d    = 4'b1111;
        end
        S_FILL: begin
          if (wr_fire) begin
            av_write_d = 1'b1;
            av_addr_d  = DATA_ADDR;
            av_wdata_d = i_WrData;
            av_be_d    = 4'b1111;
          end
        end
        S_CMD: begin
          av_write_d = 1'b1;
          av_addr_d  = CNTRL_ADDR;
          av_wdata_d = op_r ? ctrl_word(CMD_PROGRAM_PAGE, count_r)
                            : ctrl_word(CMD_SECTOR_ERASE, 7'd0);
          av_be_d    = 4'b1111;
        end
        S_SR_SEL: begin
          av_write_d = 1'b1;
          av_addr_d  = ADDR_ADDR;
          av_wdata_d = 32'd1;
          av_be_d    = 4'b1111;
        end
        S_SR_CMD: begin
          av_write_d = 1'b1;
          av_addr_d  = CNTRL_ADDR;
          av_wdata_d = ctrl_word(CMD_READ_SR, 7'd0);
          av_be_d    = 4'b1111;
        end
        S_SR_READ: begin
          av_read_d = 1'b1;
          av_addr_d = DATA_ADDR;
          av_be_d   = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  // Avalon master registers: strobes, address, data and byte enables are
  // all driven from flops so they stay stable while the slave stalls.
  always_ff @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      o_AV_Read      <= 1'b0;
      o_AV_Write     <= 1'b0;
      o_AV_Addr      <= 30'd0;
      o_AV_WriteData <= 32'd0;
      o_AV_ByteEn    <= 4'b0000;
    end else begin
      o_AV_Read      <= av_read_d;
      o_AV_Write     <= av_write_d;
      o_AV_Addr      <= av_addr_d;
      o_AV_WriteData <= av_wdata_d;
      o_AV_ByteEn    <= av_be_d;
    end
  end

  // Operand latches and counters. Words are counted when handshaken, so
  // the completion of the write carrying word N sees words_sent == N.
  always_ff @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      op_r       <= 1'b0;
      addr_r     <= 24'd0;
      count_r    <= 7'd0;
      words_sent <= 7'd0;
      poll_cnt   <= 16'd0;
    end else begin
      if (state == S_IDLE && i_Start) begin
        op_r       <= i_Op;
        addr_r     <= i_FlashAddr;
        count_r    <= i_WordCount;
        words_sent <= 7'd0;
        poll_cnt   <= 16'd0;
      end
      if (wr_fire) begin
        words_sent <= words_sent + 7'd1;
      end
      if (state == S_SR_READ && xfer_done && sr_busy) begin
        poll_cnt <= poll_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/flash_op_sequencer.md
# flash_op_sequencer

Autonomous master for the control port of the flash bus interface. It turns a single start request into the full command sequence for a page program or 4 KB sector erase: write enable, address load, data FIFO fill, command issue and status-register busy polling. CPU firmware and boot-time loaders use it instead of bit-banging the control registers. It sits between a requester and the flash interface's Avalon control slave.

## Interface
- BASE_ADDR, 30'h20000000: Avalon word address of the flash control register block (CNTRL=+0, ADDR=+1, DATA=+2).
- POLL_LIMIT, 65535: maximum SR1 polls before the sequencer gives up (16-bit counter).
- i_Clk  in  1  system clock; all logic on the rising edge.
- i_nReset  in  1  asynchronous, active-low reset.
- i_Start  in  1  one-cycle request; sampled only in IDLE.
- i_Op  in  1  0 = sector erase 4 KB, 1 = program page; latched at start.
- i_FlashAddr  in  24  flash byte address; latched at start.
- i_WordCount  in  7  words to program, 1..64; 0 and values >64 are rejected. Ignored for erase.
- i_WrData  in  32  program data word.
- i_WrValid  in  1  i_WrData valid.
- o_WrReady  out  1  word accepted when i_WrValid && o_WrReady.
- o_Busy  out  1  high in every state except IDLE.
- o_Done  out  1  one-cycle completion pulse.
- o_Error  out  1  one-cycle pulse on rejected count or poll timeout; issued instead of o_Done.
- o_AV_Addr  out  30  Avalon master word address.
- o_AV_ByteEn  out  4  always 4'b1111 during a transfer.
- o_AV_Read  out  1  Avalon read.
- o_AV_Write  out  1  Avalon write.
- o_AV_WriteData  out  32  Avalon write data.
- i_AV_ReadData  in  32  Avalon read data.
- i_AV_WaitRequest  in  1  Avalon wait request.

## Operation
- Control word layout: [3:0] command, [8] go, [22:16] word count. Commands used: WRITE_ENABLE=0, SECTOR_ERASE_4KB=2, PROGRAM_PAGE=5, READ_SR=7.
- CNTRL read: bit 31 = interface busy. DATA read after READ_SR: SR1 in [7:0], bit 0 = BUSY.
- States:
  - IDLE: on i_Start, latch operands and go to WEN. If i_Op=1 and the count is 0 or >64, go to ERR instead.
  - WEN: write CNTRL = {cmd 0, go}.
  - WEN_WAIT: read CNTRL until bit 31 = 0.
  - ADDR: write ADDR = {8'h0, addr}.
  - FILL (program only): for each handshaken word, write DATA with that word. o_WrReady is high only in FILL while no Avalon write is pending. Leave after the latched count of words.
  - CMD: write CNTRL with {2 or 5, go, count}. Count field is 0 for erase.
  - CMD_WAIT: read CNTRL until bit 31 = 0.
  - SR_CMD: write ADDR = 1 (select SR1), then write CNTRL = {7, go}.
  - SR_WAIT: read CNTRL until bit 31 = 0.
  - SR_READ: read DATA. If bit 0 = 1, increment the poll counter and return to SR_CMD. Otherwise go to DONE.
  - DONE: pulse o_Done, return to IDLE.
  - ERR: pulse o_Error, return to IDLE.
- Poll timeout: reaching POLL_LIMIT busy polls goes to ERR.
- An i_Start that arrives while busy is ignored and not queued.

## Timing
- Reset values: all outputs 0, o_AV_ByteEn = 0, state IDLE, counters cleared. Reset is asynchronous and takes effect mid-operation. An operation the flash has already accepted is not aborted; the next request's SR poll absorbs it.
- Avalon handshake:
  - o_AV_Read or o_AV_Write is asserted with address, data and byte enables registered and stable.
  - These hold until a rising edge where i_AV_WaitRequest = 0, then deassert on the next cycle.
  - At least one idle cycle between transfers. Never read and write at the same time.
- Read data is sampled on the edge where the wait request is low.
- Start to first o_AV_Write: 1 cycle, so the write is asserted in the cycle after the i_Start edge.
- o_Done / o_Error: asserted the cycle after the terminating transfer completes; high for exactly 1 cycle; o_Busy drops in that same cycle.
- A rejected count produces o_Error 1 cycle after i_Start with no Avalon activity.
- A WrValid stall in FILL holds the state indefinitely; there is no timeout there.
- Word counter is 7 bits; 64 terminates exactly with no wrap.

## Test plan
- Erase at 0x001000, slave with 0-wait and SR1 BUSY returning 1,1,0 -> writes CNTRL 0x100, ADDR 0x001000, CNTRL 0x102, then 3 SR poll loops; one o_Done; no o_WrReady ever.
- Program 4 words 1..4 at 0x000000 with WaitRequest held 2 cycles per transfer -> DATA writes 1,2,3,4 in order; CNTRL write 0x00040105; o_Done after the SR reads 0.
- Program with i_WordCount = 0 and with 65 -> o_Error pulse 1 cycle after start; zero Avalon transfers.
- SR1 BUSY stuck at 1 with POLL_LIMIT = 4 -> exactly 4 SR_READ transfers, then o_Error; no o_Done.
- i_nReset low mid-FILL, then start a 64-word program -> all outputs 0 during reset; the new run writes exactly 64 DATA words; a second i_Start during the run is ignored.
